// File: rtl/mtimer_apb.sv
`default_nettype none
// ============================================================================
// Module   : mtimer_apb
// Brief    : APB machine timer: 64-bit mtime with tick prescaler, per-hart
//            64-bit mtimecmp registers and registered timer interrupts.
// Revision : 1.0 - initial release
// ============================================================================
module mtimer_apb #(
    parameter int N_HART   = 1,
    parameter int ADDR_W   = 16,
    parameter int TICK_DIV = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              psel,
    input  logic              penable,
    output logic              pready,
    input  logic [ADDR_W-1:0] paddr,
    input  logic              pwrite,
    input  logic [31:0]       pwdata,
    input  logic [3:0]        pwstrb,
    output logic [31:0]       prdata,
    output logic              pslverr,
    output logic [63:0]       mtime,
    output logic [N_HART-1:0] mtimer_int
);

    localparam logic [ADDR_W-1:0] c_MTIME_LO = ADDR_W'(16'h7FF8);
    localparam logic [ADDR_W-1:0] c_MTIME_HI = ADDR_W'(16'h7FFC);
    localparam logic [15:0]       c_DIV_M1   = 16'(TICK_DIV - 1);
    localparam logic [63:0]       c_CMP_RST  = 64'hFFFF_FFFF_FFFF_FFFF;

    logic [63:0]       r_mtime;
    logic [15:0]       r_presc;
    logic [63:0]       r_cmp [N_HART];
    logic [N_HART-1:0] r_int;

    logic              w_access;
    logic              w_aligned;
    logic [ADDR_W-4:0] w_cmp_idx;
    logic              w_cmp_hit;
    logic              w_mt_lo;
    logic              w_mt_hi;
    logic              w_hit;
    logic              w_wr;
    logic              w_tick;
    logic [31:0]       w_rdata;

    function automatic logic [31:0] f_merge(input logic [31:0] old_v,
                                            input logic [31:0] new_v,
                                            input logic [3:0]  strb);
        logic [31:0] res;
        res = old_v;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) res[8*b +: 8] = new_v[8*b +: 8];
        end
        return res;
    endfunction

    assign w_access  = psel & penable;
    assign w_aligned = (paddr[1:0] == 2'b00);
    assign w_cmp_idx = paddr[ADDR_W-1:3];
    assign w_cmp_hit = w_aligned && (w_cmp_idx < (ADDR_W-3)'(N_HART));
    assign w_mt_lo   = (paddr == c_MTIME_LO);
    assign w_mt_hi   = (paddr == c_MTIME_HI);
    assign w_hit     = w_cmp_hit | w_mt_lo | w_mt_hi;
    assign w_wr      = w_access & pwrite & w_hit;
    assign w_tick    = (r_presc == c_DIV_M1);

    always_comb begin
        w_rdata = '0;
        if (w_mt_lo) begin
            w_rdata = r_mtime[31:0];
        end else if (w_mt_hi) begin
            w_rdata = r_mtime[63:32];
        end else if (w_cmp_hit) begin
            for (int h = 0; h < N_HART; h++) begin
                if (w_cmp_idx == (ADDR_W-3)'(h))
                    w_rdata = paddr[2] ? r_cmp[h][63:32] : r_cmp[h][31:0];
            end
        end
    end

    assign pready  = w_access;
    assign pslverr = w_access & ~w_hit;
    assign prdata  = (w_access && w_hit) ? w_rdata : 32'h0;

    // A software write to mtime takes priority over the tick and restarts the prescaler.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mtime <= '0;
            r_presc <= '0;
        end else if (w_wr && (w_mt_lo || w_mt_hi)) begin
            r_presc <= '0;
            if (w_mt_lo) r_mtime[31:0]  <= f_merge(r_mtime[31:0],  pwdata, pwstrb);
            if (w_mt_hi) r_mtime[63:32] <= f_merge(r_mtime[63:32], pwdata, pwstrb);
        end else if (w_tick) begin
            r_presc <= '0;
            r_mtime <= r_mtime + 64'd1;
        end else begin
            r_presc <= r_presc + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int h = 0; h < N_HART; h++) r_cmp[h] <= c_CMP_RST;
            r_int <= '0;
        end else begin
            for (int h = 0; h < N_HART; h++) begin
                r_int[h] <= (r_mtime >= r_cmp[h]);
                if (w_wr && w_cmp_hit && (w_cmp_idx == (ADDR_W-3)'(h))) begin
                    if (paddr[2])
                        r_cmp[h][63:32] <= f_merge(r_cmp[h][63:32], pwdata, pwstrb);
                    else
                        r_cmp[h][31:0]  <= f_merge(r_cmp[h][31:0],  pwdata, pwstrb);
                end
            end
        end
    end

    assign mtime      = r_mtime;
    assign mtimer_int = r_int;

endmodule
`default_nettype wire
